// File: rtl/cla_adder_8b_pkg.sv
// Shared constants for the carry look-ahead adder family.
package cla_adder_8b_pkg;

  localparam int unsigned CLA_GROUP  = 4;
  localparam int unsigned CLA_WIDTH  = 8;
  localparam int unsigned CLA_GROUPS = CLA_WIDTH / CLA_GROUP;

endpackage : cla_adder_8b_pkg

// File: rtl/cla_group_4b.sv
// 4-bit look-ahead group: sum bits plus group generate/propagate for the next level.
module cla_group_4b
  import cla_adder_8b_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a_i,
  input  logic [CLA_GROUP-1:0] b_i,
  input  logic                 c_in_i,
  output logic [CLA_GROUP-1:0] s_o,
  output logic                 g_o,
  output logic                 p_o
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every internal carry is a flat sum-of-products from c_in_i, never chained.
  assign c[0] = c_in_i;
  assign c[1] = g[0] | (p[0] & c_in_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in_i);

  assign s_o = p ^ c;

  assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
  assign p_o = &p;

endmodule : cla_group_4b

// File: rtl/cla_adder_8b.sv
// 8-bit two-level carry look-ahead adder with a combinational sum and a registered copy.
module cla_adder_8b
  import cla_adder_8b_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 c_i,
  output logic [CLA_WIDTH-1:0] s,
  output logic                 c_o,
  output logic [CLA_WIDTH-1:0] s_q,
  output logic                 c_o_q
);

  logic [CLA_GROUPS-1:0] grp_g;
  logic [CLA_GROUPS-1:0] grp_p;
  logic                  carry4;
  logic [CLA_WIDTH-1:0]  s_d;
  logic                  c_o_d;

  cla_group_4b u_grp_lo (
    .a_i    (a[CLA_GROUP-1:0]),
    .b_i    (b[CLA_GROUP-1:0]),
    .c_in_i (c_i),
    .s_o    (s[CLA_GROUP-1:0]),
    .g_o    (grp_g[0]),
    .p_o    (grp_p[0])
  );

  cla_group_4b u_grp_hi (
    .a_i    (a[CLA_WIDTH-1:CLA_GROUP]),
    .b_i    (b[CLA_WIDTH-1:CLA_GROUP]),
    .c_in_i (carry4),
    .s_o    (s[CLA_WIDTH-1:CLA_GROUP]),
    .g_o    (grp_g[1]),
    .p_o    (grp_p[1])
  );

  // Second-level look-ahead across the two groups.
  assign carry4 = grp_g[0] | (grp_p[0] & c_i);
  assign c_o    = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c_i);

  assign s_d   = s;
  assign c_o_d = c_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q   <= '0;
      c_o_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      c_o_q <= c_o_d;
    end
  end

endmodule : cla_adder_8b

// File: tb/tb_cla_adder_8b.sv
// Self-checking bench for cla_adder_8b: corner table, exhaustive sweep, registered/reset sequences.
module tb_cla_adder_8b;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] exp_s;
    logic       exp_co;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_i;
  logic [7:0] s;
  logic       c_o;
  logic [7:0] s_q;
  logic       c_o_q;

  int checks_total;
  int checks_passed;

  cla_adder_8b dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c_i   (c_i),
    .s     (s),
    .c_o   (c_o),
    .s_q   (s_q),
    .c_o_q (c_o_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 9-bit unsigned addition.
  function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci);
    return 9'(x) + 9'(y) + 9'(ci);
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (a=%h b=%h c_i=%b)", name, act, exp, a, b, c_i);
    else
      checks_passed++;
  endtask

  vec_t vecs[$];
  int   exh_fail;

  initial begin
    logic [8:0] exp;
    checks_total  = 0;
    checks_passed = 0;
    exh_fail      = 0;
    reset = 1'b0;
    a     = '0;
    b     = '0;
    c_i   = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("reset_s_q", 9'(s_q), 9'h000);
    chk("reset_c_o_q", 9'(c_o_q), 9'h000);

    vecs.push_back('{"ff_00_1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{"ff_ff_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{"zero",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{"grp_xing",8'h0F, 8'h01, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{"msb_wrap",8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{"ci_iso0", 8'h7F, 8'h00, 1'b0, 8'h7F, 1'b0});
    vecs.push_back('{"ci_iso1", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0});

    // Combinational path is checked while reset is still asserted.
    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; c_i = vecs[i].ci;
      #2;
      chk(vecs[i].name, {c_o, s}, {vecs[i].exp_co, vecs[i].exp_s});
    end
    chk("reset_hold_s_q", 9'(s_q), 9'h000);

    // Registered path: first edge after release loads the current sum.
    @(negedge clk);
    reset = 1'b0;
    a = 8'h12; b = 8'h34; c_i = 1'b1;
    #1;
    chk("pre_edge_s_q", {c_o_q, s_q}, 9'h000);
    @(posedge clk); #1;
    chk("post_edge_q", {c_o_q, s_q}, 9'h047);

    // Async reset between edges with C8 held.
    @(negedge clk);
    a = 8'h64; b = 8'h64; c_i = 1'b0;
    @(posedge clk); #1;
    chk("hold_c8", {c_o_q, s_q}, 9'h0C8);
    #2 reset = 1'b1;
    #1;
    chk("async_clr", {c_o_q, s_q}, 9'h000);
    chk("async_comb", {c_o, s}, 9'h0C8);
    @(posedge clk); #1;
    chk("reset_edge_q", {c_o_q, s_q}, 9'h000);
    @(negedge clk);
    reset = 1'b0;

    // Random registered-path checks against the reference model.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      a   = 8'($urandom);
      b   = 8'($urandom);
      c_i = 1'($urandom);
      exp = ref_sum(a, b, c_i);
      #1;
      chk("rand_comb", {c_o, s}, exp);
      @(posedge clk); #1;
      chk("rand_reg", {c_o_q, s_q}, exp);
    end

    // Exhaustive operand sweep with random carry-in.
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 256; ib++) begin
        a   = 8'(ia);
        b   = 8'(ib);
        c_i = 1'($urandom);
        #2;
        exp = ref_sum(a, b, c_i);
        checks_total++;
        if ({c_o, s} !== exp) begin
          exh_fail++;
          if (exh_fail <= 10)
            $display("FAIL exhaustive: got %h expected %h (a=%h b=%h c_i=%b)",
                     {c_o, s}, exp, a, b, c_i);
        end else begin
          checks_passed++;
        end
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule : tb_cla_adder_8b
